// File: rtl/jump_pkg.sv
// Shared types and default tuning constants for the sprite jump/fall controller.
package jump_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    APEX   = 2'd2,
    FALL   = 2'd3
  } jump_state_t;

  localparam int DEF_VEL_W       = 8;
  localparam int DEF_V0          = 12;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_MAX_FALL    = 8;
  localparam int DEF_CUT_VEL     = 4;
  localparam int DEF_HOLD_MIN    = 3;
  localparam int DEF_APEX_FRAMES = 2;
  localparam int DEF_COYOTE      = 4;
  localparam int DEF_BUF_FRAMES  = 4;

  // Width needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jump_ctrl_if.sv
// Player input/collision flags in, per-frame vertical motion and status out.
interface jump_ctrl_if import jump_pkg::*; #(
  parameter int VEL_W = DEF_VEL_W
);
  logic                    jump_btn;
  logic                    hit_ground;
  logic                    hit_ceiling;
  logic signed [VEL_W-1:0] jump_y_motion;
  logic                    airborne;
  logic                    jump_start;
  logic                    landed;
  jump_state_t             state_o;

  modport master (
    output jump_btn, hit_ground, hit_ceiling,
    input  jump_y_motion, airborne, jump_start, landed, state_o
  );

  modport slave (
    input  jump_btn, hit_ground, hit_ceiling,
    output jump_y_motion, airborne, jump_start, landed, state_o
  );
endinterface

// File: rtl/sat_down_ctr.sv
// Loadable down-counter that parks at zero; used for jump buffer, coyote and apex timers.
module sat_down_ctr #(
  parameter int W = 4
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge frame_clk) begin
    if (Reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/jump_ctrl.sv
// Per-frame gravity-model jump controller: variable height, coyote time, jump buffer,
// ceiling bump and terminal fall speed. Negative velocity means upward.
module jump_ctrl import jump_pkg::*; #(
  parameter int VEL_W       = DEF_VEL_W,
  parameter int V0          = DEF_V0,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int MAX_FALL    = DEF_MAX_FALL,
  parameter int CUT_VEL     = DEF_CUT_VEL,
  parameter int HOLD_MIN    = DEF_HOLD_MIN,
  parameter int APEX_FRAMES = DEF_APEX_FRAMES,
  parameter int COYOTE      = DEF_COYOTE,
  parameter int BUF_FRAMES  = DEF_BUF_FRAMES
) (
  input  logic        frame_clk,
  input  logic        Reset,
  jump_ctrl_if.slave  bus
);

  localparam int BUF_W  = cnt_width(BUF_FRAMES);
  localparam int COY_W  = cnt_width(COYOTE);
  localparam int APX_W  = cnt_width(APEX_FRAMES);
  localparam int RISE_W = cnt_width(HOLD_MIN);

  localparam logic signed [VEL_W:0]   GRAV_X = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   MAX_X  = (VEL_W+1)'(MAX_FALL);
  localparam logic signed [VEL_W:0]   CUT_X  = (VEL_W+1)'(-CUT_VEL);
  localparam logic signed [VEL_W-1:0] LAUNCH = VEL_W'(-V0);
  localparam logic signed [VEL_W-1:0] GRAV_V = VEL_W'(GRAVITY);

  if (V0 >= 2**(VEL_W-1)) begin : g_chk_v0
    $error("jump_ctrl: V0 does not fit in signed VEL_W");
  end
  if (MAX_FALL >= 2**(VEL_W-1)) begin : g_chk_max_fall
    $error("jump_ctrl: MAX_FALL does not fit in signed VEL_W");
  end
  if (CUT_VEL > V0) begin : g_chk_cut
    $error("jump_ctrl: CUT_VEL must not exceed V0");
  end

  jump_state_t             state;
  logic signed [VEL_W-1:0] vel;
  logic                    btn_q;
  logic [RISE_W-1:0]       rise_cnt;
  logic                    js_q;
  logic                    ld_q;

  logic [BUF_W-1:0] buf_cnt, buf_val;
  logic [COY_W-1:0] coy_cnt, coy_val;
  logic [APX_W-1:0] apx_cnt;
  logic             buf_zero, coy_zero, apx_zero;
  logic             buf_load, coy_load, apx_load;

  logic                  press, want, coy_last, apx_last;
  logic                  ground_jump, fall_jump, do_jump, enter_apex;
  logic signed [VEL_W:0] sum, rise_nv, fall_nv;

  // One guard bit keeps the gravity step from wrapping before clamping.
  always_comb begin
    press       = bus.jump_btn & ~btn_q;
    want        = press | ~buf_zero;
    coy_last    = coy_zero | (coy_cnt == COY_W'(1));
    apx_last    = apx_zero | (apx_cnt == APX_W'(1));
    sum         = {vel[VEL_W-1], vel} + GRAV_X;
    rise_nv     = sum;
    if ((rise_cnt >= RISE_W'(HOLD_MIN)) && !bus.jump_btn && (sum < CUT_X))
      rise_nv = CUT_X;
    fall_nv     = (sum > MAX_X) ? MAX_X : sum;
    ground_jump = (state == GROUND) & want & (bus.hit_ground | ~coy_zero);
    fall_jump   = (state == FALL) & bus.hit_ground & want;
    do_jump     = ground_jump | fall_jump;
    enter_apex  = (state == RISE) & (bus.hit_ceiling | ~rise_nv[VEL_W]);
    buf_load    = do_jump | press;
    buf_val     = do_jump ? '0 : BUF_W'(BUF_FRAMES);
    coy_load    = do_jump | ((state == GROUND) & bus.hit_ground);
    coy_val     = do_jump ? '0 : COY_W'(COYOTE);
    apx_load    = enter_apex;
  end

  sat_down_ctr #(.W(BUF_W)) u_buf_ctr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (buf_load),
    .load_val  (buf_val),
    .count     (buf_cnt),
    .zero      (buf_zero)
  );

  sat_down_ctr #(.W(COY_W)) u_coy_ctr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (coy_load),
    .load_val  (coy_val),
    .count     (coy_cnt),
    .zero      (coy_zero)
  );

  sat_down_ctr #(.W(APX_W)) u_apx_ctr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (apx_load),
    .load_val  (APX_W'(APEX_FRAMES)),
    .count     (apx_cnt),
    .zero      (apx_zero)
  );

  // btn_q resets high so a key held through reset is not seen as a fresh press.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state    <= GROUND;
      vel      <= '0;
      btn_q    <= 1'b1;
      rise_cnt <= '0;
      js_q     <= 1'b0;
      ld_q     <= 1'b0;
    end else begin
      btn_q <= bus.jump_btn;
      js_q  <= 1'b0;
      ld_q  <= 1'b0;
      case (state)
        GROUND: begin
          if (ground_jump) begin
            state    <= RISE;
            vel      <= LAUNCH;
            js_q     <= 1'b1;
            rise_cnt <= RISE_W'(1);
          end else begin
            vel <= '0;
            if (!bus.hit_ground && coy_last)
              state <= FALL;
          end
        end
        RISE: begin
          if (rise_cnt < RISE_W'(HOLD_MIN))
            rise_cnt <= rise_cnt + RISE_W'(1);
          if (enter_apex) begin
            state <= APEX;
            vel   <= '0;
          end else begin
            vel <= rise_nv[VEL_W-1:0];
          end
        end
        APEX: begin
          vel <= '0;
          if (bus.hit_ground) begin
            state <= GROUND;
            ld_q  <= 1'b1;
          end else if (apx_last) begin
            state <= FALL;
            vel   <= GRAV_V;
          end
        end
        FALL: begin
          if (bus.hit_ground) begin
            ld_q <= 1'b1;
            if (want) begin
              state    <= RISE;
              vel      <= LAUNCH;
              js_q     <= 1'b1;
              rise_cnt <= RISE_W'(1);
            end else begin
              state <= GROUND;
              vel   <= '0;
            end
          end else begin
            vel <= fall_nv[VEL_W-1:0];
          end
        end
        default: begin
          state <= GROUND;
          vel   <= '0;
        end
      endcase
    end
  end

  assign bus.jump_y_motion = vel;
  assign bus.airborne      = (state != GROUND);
  assign bus.jump_start    = js_q;
  assign bus.landed        = ld_q;
  assign bus.state_o       = state;

endmodule
